// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the uDLX five-stage pipeline registers. Produces
//   per-stage load enables and bubble-insert flushes from load-use hazards,
//   taken branches resolved in EX and multi-cycle data-memory accesses in MEM.
//   Also purges the pipeline after reset, flags memory timeouts and counts
//   stall cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1_addr, id_rs2_addr   source registers of the instruction in ID
//   id_uses_rs2                ID instruction reads rs2
//   ex_is_load                 EX instruction is a load
//   ex_reg_wr_addr             destination register of the EX instruction
//   branch_taken               taken branch/jump resolved in EX
//   mem_req, mem_ack           MEM-stage data access request / completion
//   pc_en                      PC update enable
//   *_en, *_flush              stage register load enable / load bubble
//   mem_timeout_err            sticky: a memory access was aborted
//   stall_cycles               saturating count of cycles with pc_en=0
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned INIT_CYCLES    = 4,
   parameter int unsigned MEM_TIMEOUT    = 255,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      id_uses_rs2,
   input  logic                      ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
   input  logic                      branch_taken,
   input  logic                      mem_req,
   input  logic                      mem_ack,
   output logic                      pc_en,
   output logic                      if_id_en,
   output logic                      id_ex_en,
   output logic                      ex_mem_en,
   output logic                      mem_wb_en,
   output logic                      if_id_flush,
   output logic                      id_ex_flush,
   output logic                      ex_mem_flush,
   output logic                      mem_wb_flush,
   output logic                      mem_timeout_err,
   output logic [CNT_WIDTH-1:0]      stall_cycles
);

   localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
   localparam int unsigned ToW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      StInit,
      StRun,
      StMemWait
   } state_e;

   state_e               state_q, state_d;
   logic [InitW-1:0]     init_cnt_q, init_cnt_d;
   logic [ToW-1:0]       to_cnt_q, to_cnt_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;

   logic hazard_eval;
   logic freeze;
   logic load_use;

   // Register 0 is hardwired to zero, so a load targeting it never forwards.
   assign load_use = ex_is_load && (ex_reg_wr_addr != '0) &&
                     ((ex_reg_wr_addr == id_rs1_addr) ||
                      (id_uses_rs2 && (ex_reg_wr_addr == id_rs2_addr)));

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      to_cnt_d     = to_cnt_q;
      err_d        = err_q;
      hazard_eval  = 1'b0;
      freeze       = 1'b0;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      case (state_q)
         StInit: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            if (init_cnt_q == InitW'(INIT_CYCLES)) begin
               state_d = StRun;
            end else begin
               init_cnt_d = init_cnt_q + InitW'(1);
            end
         end
         StRun: begin
            if (mem_req && !mem_ack) begin
               freeze   = 1'b1;
               state_d  = StMemWait;
               to_cnt_d = ToW'(1);
            end else begin
               hazard_eval = 1'b1;
            end
         end
         StMemWait: begin
            if (mem_ack) begin
               // Ack wins over timeout on the same cycle.
               hazard_eval = 1'b1;
               state_d     = StRun;
            end else if (to_cnt_q == ToW'(MEM_TIMEOUT)) begin
               // Abort: drop the access and write a bubble back.
               err_d        = 1'b1;
               mem_wb_flush = 1'b1;
               state_d      = StRun;
            end else begin
               freeze   = 1'b1;
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         default: state_d = StInit;
      endcase

      if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end

      // Branch flush kills the dependent ID instruction, so it masks load-use.
      if (hazard_eval) begin
         if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end

      stall_d = stall_q;
      if ((state_q != StInit) && !pc_en && (stall_q != '1)) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
         stall_q    <= stall_d;
      end
   end

   assign mem_timeout_err = err_q;
   assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (INIT_CYCLES=4, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 16;

   // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
   //        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
   localparam logic [8:0] C_INIT   = 9'b0_0000_1111;
   localparam logic [8:0] C_RUN    = 9'b1_1111_0000;
   localparam logic [8:0] C_FREEZE = 9'b0_0001_0001;
   localparam logic [8:0] C_LDUSE  = 9'b0_0111_0100;
   localparam logic [8:0] C_BRANCH = 9'b1_1111_1100;
   localparam logic [8:0] C_ABORT  = 9'b1_1111_0001;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_reg_wr_addr;
   logic          id_uses_rs2, ex_is_load, branch_taken, mem_req, mem_ack;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic          mem_timeout_err;
   logic [CW-1:0] stall_cycles;
   logic [8:0]    ctl;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_ADDR_WIDTH(AW),
      .INIT_CYCLES   (4),
      .MEM_TIMEOUT   (8),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_rs1_addr    (id_rs1_addr),
      .id_rs2_addr    (id_rs2_addr),
      .id_uses_rs2    (id_uses_rs2),
      .ex_is_load     (ex_is_load),
      .ex_reg_wr_addr (ex_reg_wr_addr),
      .branch_taken   (branch_taken),
      .mem_req        (mem_req),
      .mem_ack        (mem_ack),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .id_ex_en       (id_ex_en),
      .ex_mem_en      (ex_mem_en),
      .mem_wb_en      (mem_wb_en),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_flush   (ex_mem_flush),
      .mem_wb_flush   (mem_wb_flush),
      .mem_timeout_err(mem_timeout_err),
      .stall_cycles   (stall_cycles)
   );

   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   typedef struct {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic          uses_rs2;
      logic          is_load;
      logic [AW-1:0] wr;
      logic          br;
      logic          req;
      logic          ack;
      logic [8:0]    exp_ctl;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic uses, input logic ld, input logic [AW-1:0] wr,
                               input logic br, input logic req, input logic ack,
                               input logic [8:0] e);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.uses_rs2 = uses; v.is_load = ld; v.wr = wr;
      v.br = br; v.req = req; v.ack = ack; v.exp_ctl = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
      ex_reg_wr_addr = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      vecs[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_RUN);
      vecs[1]  = mk(5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, C_LDUSE);
      vecs[2]  = mk(5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_RUN);
      vecs[3]  = mk(5'd1,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, C_RUN);
      vecs[4]  = mk(5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, C_LDUSE);
      vecs[5]  = mk(5'd5,  5'd5,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, C_RUN);
      vecs[6]  = mk(5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, C_BRANCH);
      vecs[7]  = mk(5'd3,  5'd4,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, C_BRANCH);
      vecs[8]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, C_RUN);
      vecs[9]  = mk(5'd12, 5'd0,  1'b0, 1'b1, 5'd12, 1'b0, 1'b1, 1'b1, C_LDUSE);
      vecs[10] = mk(5'd30, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, C_LDUSE);

      idle_inputs();
      rst_n = 1'b0;
      #2;
      chk("reset ctl", 32'(ctl), 32'(C_INIT));
      chk("reset stall", 32'(stall_cycles), 32'd0);
      chk("reset err", 32'(mem_timeout_err), 32'd0);
      tick();
      rst_n = 1'b1;

      // Four full INIT cycles after release, RUN after the fifth edge.
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("init cycle %0d ctl", i), 32'(ctl), 32'(C_INIT));
      end
      tick();
      chk("first run ctl", 32'(ctl), 32'(C_RUN));
      chk("first run stall", 32'(stall_cycles), 32'd0);

      for (int i = 0; i < 11; i++) begin
         id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2;
         id_uses_rs2 = vecs[i].uses_rs2; ex_is_load = vecs[i].is_load;
         ex_reg_wr_addr = vecs[i].wr; branch_taken = vecs[i].br;
         mem_req = vecs[i].req; mem_ack = vecs[i].ack;
         #1;
         chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
         if (vecs[i].exp_ctl[8] == 1'b0) exp_stall++;
         tick();
         chk($sformatf("vec%0d stall", i), 32'(stall_cycles), 32'(exp_stall));
      end
      idle_inputs();

      // Three-cycle memory wait, branch ignored while frozen, evaluated on release.
      mem_req = 1'b1; branch_taken = 1'b1; #1;
      chk("memwait run-freeze ctl", 32'(ctl), 32'(C_FREEZE));
      tick();
      branch_taken = 1'b0; #1;
      chk("memwait freeze2 ctl", 32'(ctl), 32'(C_FREEZE));
      tick();
      chk("memwait freeze3 ctl", 32'(ctl), 32'(C_FREEZE));
      tick();
      mem_ack = 1'b1; branch_taken = 1'b1; #1;
      chk("memwait release ctl", 32'(ctl), 32'(C_BRANCH));
      tick();
      exp_stall += 3;
      idle_inputs(); #1;
      chk("memwait back to run", 32'(ctl), 32'(C_RUN));
      chk("memwait stall", 32'(stall_cycles), 32'(exp_stall));

      // Ack arrives on the timeout cycle: normal release, no error.
      mem_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("late ack freeze %0d", i), 32'(ctl), 32'(C_FREEZE));
         tick();
      end
      mem_ack = 1'b1; #1;
      chk("late ack release ctl", 32'(ctl), 32'(C_RUN));
      tick();
      exp_stall += 8;
      idle_inputs(); #1;
      chk("late ack err", 32'(mem_timeout_err), 32'd0);
      chk("late ack stall", 32'(stall_cycles), 32'(exp_stall));

      // No ack: abort on the eighth wait cycle.
      mem_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("timeout freeze %0d", i), 32'(ctl), 32'(C_FREEZE));
         tick();
      end
      #1;
      chk("timeout abort ctl", 32'(ctl), 32'(C_ABORT));
      chk("timeout err before edge", 32'(mem_timeout_err), 32'd0);
      tick();
      exp_stall += 8;
      idle_inputs(); #1;
      chk("timeout err set", 32'(mem_timeout_err), 32'd1);
      chk("timeout back to run", 32'(ctl), 32'(C_RUN));
      chk("timeout stall", 32'(stall_cycles), 32'(exp_stall));
      tick();
      chk("timeout err sticky", 32'(mem_timeout_err), 32'd1);

      // Asynchronous reset while in MEM_WAIT.
      mem_req = 1'b1;
      tick();
      chk("pre-reset freeze", 32'(ctl), 32'(C_FREEZE));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async reset ctl", 32'(ctl), 32'(C_INIT));
      chk("async reset err", 32'(mem_timeout_err), 32'd0);
      chk("async reset stall", 32'(stall_cycles), 32'd0);
      tick();
      chk("held reset ctl", 32'(ctl), 32'(C_INIT));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the uDLX five-stage pipeline registers (if_id, id_ex, ex_mem, mem_wb).
- Generates per-stage enable (hold) and flush (bubble insert) controls from three sources: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory (SDRAM) accesses in MEM.
- Also drives a reset-time pipeline purge, a memory-timeout error flag and a stall performance counter.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
INIT_CYCLES, 4, cycles of full-pipeline flush after reset release (>=1)
MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort (>=1)
CNT_WIDTH, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_rs1_addr  in  REG_ADDR_WIDTH  source reg 1 of instruction in ID
id_rs2_addr  in  REG_ADDR_WIDTH  source reg 2 of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2
ex_is_load  in  1  instruction in EX is a load
ex_reg_wr_addr  in  REG_ADDR_WIDTH  destination of instruction in EX
branch_taken  in  1  taken branch/jump resolved in EX this cycle
mem_req  in  1  MEM stage instruction accesses data memory
mem_ack  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (zeros) into stage register
mem_timeout_err  out  1  sticky: memory access aborted on timeout
stall_cycles  out  CNT_WIDTH  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT

Behaviour:
- State machine: INIT, RUN, MEM_WAIT. Registered state and counters; control outputs are a combinational decode of state and inputs.
- Reset (rst_n low, async):
  - state=INIT, init counter=0, timeout counter=0, mem_timeout_err=0, stall_cycles=0.
  - Outputs during reset and INIT: all *_en=0, all *_flush=1, pc_en=0.
- INIT: counter increments each cycle. After INIT_CYCLES cycles in INIT, go to RUN. With INIT_CYCLES=4, the first RUN cycle is the 5th edge after deassertion.
- RUN defaults: all enables=1, all flushes=0.
- Decision priority in RUN, highest first:
  1. Memory wait: mem_req=1 and mem_ack=0.
     - pc_en, if_id_en, id_ex_en, ex_mem_en=0; mem_wb_flush=1.
     - Branch and load-use are ignored this cycle.
     - Next state MEM_WAIT, timeout counter=1.
     - mem_req=1 with mem_ack=1 in the same cycle is a single-cycle access: no stall.
  2. Branch: branch_taken=1 gives if_id_flush=1 and id_ex_flush=1 for one cycle; enables stay 1.
  3. Load-use: ex_is_load=1, ex_reg_wr_addr!=0, and (ex_reg_wr_addr==id_rs1_addr, or id_uses_rs2=1 and ex_reg_wr_addr==id_rs2_addr).
     - pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle; other stages advance.
     - Not asserted if a branch is taken in the same cycle, since the branch flush kills the dependent instruction.
     - Register 0 never causes a stall.
- MEM_WAIT:
  - mem_ack=0: freeze as in item 1. Timeout counter increments.
  - mem_ack=1: release cycle. All enables=1, mem_wb_flush=0. Branch and load-use are evaluated exactly as in RUN. Next state RUN.
  - Timeout: counter==MEM_TIMEOUT while mem_ack=0 forces an abort.
    - Set mem_timeout_err (sticky until reset).
    - This cycle: all enables=1 and mem_wb_flush=1, so the access is dropped and a bubble is written back.
    - Next state RUN.
  - mem_ack arriving on the timeout cycle takes precedence: normal release, no error.
- stall_cycles: +1 on every RUN/MEM_WAIT cycle with pc_en=0; saturates at all ones. Not counted in INIT.
- Reset asserted mid-operation (any state): immediate return to INIT outputs; counters and error cleared.

Test Plan:
- Reset release with INIT_CYCLES=4 -> all flush=1/en=0 for 4 cycles, then all en=1, flush=0; stall_cycles=0.
- ex_is_load=1, ex_reg_wr_addr=5, id_rs1_addr=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with addr 0 -> no stall. Repeat with rs2 match and id_uses_rs2=0 -> no stall.
- branch_taken=1 together with load-use match -> if_id_flush=id_ex_flush=1, pc_en=1; no stall counted.
- mem_req=1, mem_ack low for 3 cycles then high -> 3 frozen cycles with mem_wb_flush=1, release on the 4th; stall_cycles +3. mem_req=1 with mem_ack=1 in one cycle -> no stall.
- MEM_TIMEOUT=8, mem_ack never asserted -> abort after 8 wait cycles; mem_timeout_err=1 and stays 1; back in RUN. Repeat with mem_ack on the 8th cycle -> no error.
- rst_n pulsed low during MEM_WAIT -> outputs go to INIT values asynchronously; mem_timeout_err=0, stall_cycles=0.
